// File: rtl/uart_console.sv
// uart_console: APB write-only printf sink.
// Bytes feed a sim-only line buffer and an 8N1 UART via a TX FIFO.
module uart_console #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int LINE_LEN = 128,
  parameter int IDLE_FLUSH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic        tx_o,
  output logic        overflow_o,
  output logic [31:0] char_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic       accept;
  logic [7:0] wbyte;
  logic       unused;

  assign accept = psel_i & penable_i & pwrite_i
                & (paddr_i == CONSOLE_ADDR);
  assign wbyte = pwdata_i[7:0];
  assign pready_o = 1'b1;
  assign unused = ^pwdata_i[31:8];

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q, fill;
  logic        empty, full, push, pop;
  logic [31:0] char_cnt_q;
  logic        ovf_q;

  assign fill = wr_q - rd_q;
  assign empty = (fill == '0);
  assign full = (fill == FULL_CNT);
  // A pop in the same cycle frees the slot the push needs.
  assign push = accept & (~full | pop);
  assign overflow_o = ovf_q;
  assign char_cnt_o = char_cnt_q;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q[AW-1:0]] <= wbyte;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      char_cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + PTR_ONE;
      if (pop) rd_q <= rd_q + PTR_ONE;
      if (accept) char_cnt_q <= char_cnt_q + 32'd1;
      if (accept & ~push) ovf_q <= 1'b1;
    end
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tick;

  assign tick = (cnt_q == LAST_TICK);

  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          state_d = S_START;
        end
      end
      S_START: if (tick) state_d = S_DATA;
      S_DATA: if (tick && bit_q == 3'd7) state_d = S_STOP;
      S_STOP: begin
        // Chain straight into the next frame: no idle gap.
        if (tick) begin
          if (!empty) begin
            pop = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      if (pop) begin
        shift_q <= mem[rd_q[AW-1:0]];
        cnt_q <= '0;
        bit_q <= '0;
      end else if (state_q != S_IDLE) begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
        if (state_q == S_DATA && tick) begin
          shift_q <= {1'b1, shift_q[7:1]};
          bit_q <= bit_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    unique case (state_q)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shift_q[0];
      default: tx_o = 1'b1;
    endcase
  end

`ifndef SYNTHESIS
  string line_q;
  string line_app;
  string last_line;
  int    idle_q;
  int    print_cnt;
  logic  unused_sim;

  assign unused_sim = (last_line.len() != 0);

  always_comb line_app = $sformatf("%s%c", line_q, wbyte);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q <= "";
      idle_q <= 0;
    end else if (accept) begin
      idle_q <= 0;
      if (wbyte == 8'h0A) begin
        $display("[uart_console] %s", line_q);
        print_cnt <= print_cnt + 1;
        last_line <= line_q;
        line_q <= "";
      end else if (wbyte != 8'h0D) begin
        if (line_app.len() >= LINE_LEN) begin
          $display("[uart_console] %s", line_app);
          print_cnt <= print_cnt + 1;
          last_line <= line_app;
          line_q <= "";
        end else begin
          line_q <= line_app;
        end
      end
    end else if (line_q.len() != 0) begin
      if (idle_q == IDLE_FLUSH - 1) begin
        $display("[uart_console] %s", line_q);
        print_cnt <= print_cnt + 1;
        last_line <= line_q;
        line_q <= "";
        idle_q <= 0;
      end else begin
        idle_q <= idle_q + 1;
      end
    end else begin
      idle_q <= 0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_console.sv
// tb_uart_console: vectors, sequences and random traffic
// against a queue-based console/UART reference model.
module tb_uart_console;
  localparam logic [31:0] CADDR = 32'h1000_0000;
  localparam int CPB = 16;
  localparam int DEPTH = 16;
  localparam int LLEN = 128;
  localparam int IFL = 8;
  localparam int FRAME = 10 * CPB;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic        pwrite_i = 1'b0;
  logic [31:0] paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic        pready_o;
  logic        tx_o;
  logic        overflow_o;
  logic [31:0] char_cnt_o;

  uart_console #(
    .CONSOLE_ADDR(CADDR),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .LINE_LEN(LLEN),
    .IDLE_FLUSH(IFL)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .psel_i(psel_i),
    .penable_i(penable_i),
    .pwrite_i(pwrite_i),
    .paddr_i(paddr_i),
    .pwdata_i(pwdata_i),
    .pready_o(pready_o),
    .tx_o(tx_o),
    .overflow_o(overflow_o),
    .char_cnt_o(char_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_cnt;
  bit          m_ovf;
  logic [7:0]  m_q[$];
  longint      m_free_at = 0;
  longint      cyc = 0;
  logic [7:0]  exp_tx[$];
  time         exp_t[$];
  logic [7:0]  rx[$];
  time         rx_t[$];
  string       m_line = "";
  string       m_last = "";
  int          m_idle = 0;
  int          m_prints = 0;
  bit          printed;
  bit          mon_en = 1'b1;

  typedef struct {
    bit          sel;
    bit          en;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  data;
    bit          acc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act,
                       input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic void m_print(input string s);
    m_prints++;
    m_last = s;
    printed = 1'b1;
  endfunction

  // Console model: FIFO as a queue, serializer as a busy-until time.
  task automatic model_edge(input bit rst, input bit acc,
                            input logic [7:0] b);
    bit pop;
    bit ok;
    printed = 1'b0;
    if (rst) begin
      m_cnt = '0;
      m_ovf = 1'b0;
      m_q.delete();
      m_free_at = cyc;
      m_line = "";
      m_idle = 0;
    end else begin
      pop = (m_q.size() != 0) && (cyc >= m_free_at);
      ok = 1'b0;
      if (acc) begin
        m_cnt++;
        if (m_q.size() < DEPTH || pop) ok = 1'b1;
        else m_ovf = 1'b1;
      end
      if (pop) begin
        exp_tx.push_back(m_q.pop_front());
        exp_t.push_back($time);
        m_free_at = cyc + FRAME;
      end
      if (ok) m_q.push_back(b);
      if (acc) begin
        m_idle = 0;
        if (b == 8'h0A) begin
          m_print(m_line);
          m_line = "";
        end else if (b != 8'h0D) begin
          m_line = $sformatf("%s%c", m_line, b);
          if (m_line.len() == LLEN) begin
            m_print(m_line);
            m_line = "";
          end
        end
      end else if (m_line.len() != 0) begin
        m_idle++;
        if (m_idle == IFL) begin
          m_print(m_line);
          m_line = "";
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
    end
    cyc++;
  endtask

  task automatic step(input bit rst, input bit sel, input bit en,
                      input bit wr, input logic [31:0] addr,
                      input logic [7:0] d);
    rst_i = rst;
    psel_i = sel;
    penable_i = en;
    pwrite_i = wr;
    paddr_i = addr;
    pwdata_i = {24'($urandom), d};
    @(posedge clk_i);
    model_edge(rst, sel & en & wr & (addr == CADDR), d);
    #1;
    if (printed) begin
      chk("print_cnt", 64'(dut.print_cnt), 64'(m_prints));
      chk_s("print_text", dut.last_line, m_last);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 8'h0);
  endtask

  task automatic wrb(input logic [7:0] d);
    step(0, 1, 1, 1, CADDR, d);
  endtask

  task automatic wr_str(input string s);
    for (int i = 0; i < s.len(); i++) wrb(s[i]);
  endtask

  task automatic clr();
    rx.delete();
    rx_t.delete();
    exp_tx.delete();
    exp_t.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((m_q.size() != 0 || cyc < m_free_at + 2) && n < 8000) begin
      idle(1);
      n++;
    end
    chk({tag, "_rx_n"}, 64'(rx.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < rx.size(); i++) begin
      chk({tag, "_rx_byte"}, 64'(rx[i]), 64'(exp_tx[i]));
      chk({tag, "_rx_time"}, 64'(rx_t[i]), 64'(exp_t[i]));
    end
  endtask

  // UART receiver: samples mid-bit on the falling clock edge.
  time        mon_t0;
  logic [7:0] mon_b;
  always begin
    @(negedge tx_o);
    if (mon_en && !rst_i) begin
      mon_t0 = $time;
      repeat (CPB / 2) @(negedge clk_i);
      chk("start_bit", 64'(tx_o), 64'(0));
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk_i);
        mon_b[i] = tx_o;
      end
      repeat (CPB) @(negedge clk_i);
      chk("stop_bit", 64'(tx_o), 64'(1));
      rx.push_back(mon_b);
      rx_t.push_back(mon_t0);
    end
  end

  initial begin
    int   exp_cnt;
    int   p0;
    int   lows;
    logic [31:0] c0;

    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h0, 8'h0);
    idle(1);
    chk("rst_tx", 64'(tx_o), 64'(1));
    chk("rst_cnt", 64'(char_cnt_o), 64'(0));
    chk("rst_ovf", 64'(overflow_o), 64'(0));
    chk("rst_pready", 64'(pready_o), 64'(1));

    wrb(8'h48); idle(1);
    wrb(8'h69); idle(1);
    wrb(8'h0A);
    chk_s("hi_line", dut.last_line, "Hi");
    chk("hi_cnt", 64'(char_cnt_o), 64'(3));
    drain("hi");
    if (rx.size() >= 3) begin
      chk("hi_b0", 64'(rx[0]), 64'h48);
      chk("hi_b1", 64'(rx[1]), 64'h69);
      chk("hi_b2", 64'(rx[2]), 64'h0A);
      chk("hi_gap", 64'(rx_t[1] - rx_t[0]), 64'(FRAME * 10));
    end
    clr();

    vt[0] = '{1, 1, 1, 32'h1000_0004, 8'h41, 0};
    vt[1] = '{1, 1, 0, CADDR, 8'h41, 0};
    vt[2] = '{0, 1, 1, CADDR, 8'h41, 0};
    vt[3] = '{1, 0, 1, CADDR, 8'h41, 0};
    vt[4] = '{1, 1, 1, 32'h0000_0000, 8'h41, 0};
    vt[5] = '{1, 1, 1, 32'h1000_0001, 8'h41, 0};
    vt[6] = '{1, 1, 1, CADDR, 8'h0D, 1};
    vt[7] = '{1, 1, 1, CADDR, 8'h0D, 1};
    exp_cnt = 3;
    p0 = m_prints;
    for (int i = 0; i < 8; i++) begin
      step(0, vt[i].sel, vt[i].en, vt[i].wr, vt[i].addr, vt[i].data);
      exp_cnt += int'(vt[i].acc);
      chk("vec_cnt", 64'(char_cnt_o), 64'(exp_cnt));
      if (!vt[i].acc) chk("vec_tx_idle", 64'(tx_o), 64'(1));
    end
    idle(12);
    chk("vec_no_print", 64'(dut.print_cnt), 64'(p0));
    drain("vec");
    clr();

    p0 = m_prints;
    wr_str("Hello, world!");
    idle(7);
    chk("hello_early", 64'(dut.print_cnt), 64'(p0));
    idle(1);
    chk("hello_flush", 64'(dut.print_cnt), 64'(p0 + 1));
    chk_s("hello_text", dut.last_line, "Hello, world!");
    idle(2);
    chk("hello_once", 64'(dut.print_cnt), 64'(p0 + 1));
    drain("hello");
    clr();

    c0 = m_cnt;
    for (int i = 0; i < 20; i++) wrb(8'($urandom_range(33, 126)));
    chk("burst_cnt", 64'(char_cnt_o), 64'(c0 + 32'd20));
    chk("burst_ovf", 64'(overflow_o), 64'(1));
    drain("burst");
    chk("burst_rx_n17", 64'(rx.size()), 64'(17));
    clr();

    for (int i = 0; i < LLEN; i++) wrb(8'h61 + 8'(i % 26));
    chk("line_full_len", 64'(dut.last_line.len()), 64'(LLEN));
    wr_str("zz");
    idle(10);
    chk_s("line_tail", dut.last_line, "zz");
    drain("line");
    clr();

    for (int i = 0; i < 400; i++) begin
      int r;
      int k;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 19);
      d = (k == 0) ? 8'h0A : (k == 1) ? 8'h0D
        : 8'($urandom_range(32, 126));
      if (r < 5) wrb(d);
      else if (r == 5)
        step(0, 1, 1, 1, CADDR ^ (32'h1 << $urandom_range(0, 31)), d);
      else if (r == 6) step(0, 1, 1, 0, CADDR, d);
      else if (r == 7) step(0, 1, 0, 1, CADDR, d);
      else if (r == 8) idle(1);
      else idle($urandom_range(1, 12));
    end
    chk("rand_cnt", 64'(char_cnt_o), 64'(m_cnt));
    chk("rand_ovf", 64'(overflow_o), 64'(m_ovf));
    drain("rand");
    chk("rand_prints", 64'(dut.print_cnt), 64'(m_prints));
    clr();

    mon_en = 1'b0;
    wr_str("xyz");
    idle(3);
    chk("rst_pre_tx", 64'(tx_o), 64'(0));
    step(1, 0, 0, 0, 32'h0, 8'h0);
    chk("rst_mid_tx", 64'(tx_o), 64'(1));
    chk("rst_mid_cnt", 64'(char_cnt_o), 64'(0));
    chk("rst_mid_ovf", 64'(overflow_o), 64'(0));
    chk("rst_mid_print", 64'(dut.print_cnt), 64'(m_prints));
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      idle(1);
      if (tx_o == 1'b0) lows++;
    end
    chk("rst_fifo_empty", 64'(lows), 64'(0));
    chk("rst_no_partial", 64'(dut.print_cnt), 64'(m_prints));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
